gate_unit_arbiter: RTL and testbench

GATE_UNIT_ARBITER -- requirements
Module: gate_unit_arbiter

---
 rtl/gate_unit_arbiter_if.sv | 29 ++
 rtl/gate_unit_arbiter.sv | 97 +++++++++
 tb/tb_gate_unit_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_unit_arbiter_if.sv
// Request/grant/result bundle between two requesters and the gate unit arbiter.
// The master side drives requests and operands; the slave side returns grants and results.
interface gate_unit_arbiter_if;
   logic       iReq0;
   logic [1:0] iOp0;
   logic       iA0;
   logic       iB0;
   logic       iReq1;
   logic [1:0] iOp1;
   logic       iA1;
   logic       iB1;
   logic       oGnt0;
   logic       oGnt1;
   logic       oResult;
   logic       oValid;
   logic       oId;
   logic       oBusy;
   logic [7:0] oCount;

   modport master (
      output iReq0, iOp0, iA0, iB0, iReq1, iOp1, iA1, iB1,
      input  oGnt0, oGnt1, oResult, oValid, oId, oBusy, oCount
   );

   modport slave (
      input  iReq0, iOp0, iA0, iB0, iReq1, iOp1, iA1, iB1,
      output oGnt0, oGnt1, oResult, oValid, oId, oBusy, oCount
   );
endinterface

// File: rtl/gate_unit_arbiter.sv
// Two-requester round-robin arbiter feeding a single 1-bit gate unit.
// Each operation takes IDLE -> EXEC -> DONE; requests outside IDLE are ignored.
module gate_unit_arbiter (
   input logic                 iClk,
   input logic                 iRst,
   gate_unit_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StExec, StDone} stateT;

   stateT      stateQ, stateD;
   logic       anyReq;
   logic       winner;
   logic       lastQ;
   logic       idQ;
   logic [1:0] opQ;
   logic       aQ;
   logic       bQ;
   logic       gateOut;
   logic       resultQ;
   logic       ownerQ;
   logic [7:0] countQ;

   // On a tie the requester not served last wins; lastQ resets to 1 so requester 0 goes first.
   always_comb begin
      anyReq = bus.iReq0 | bus.iReq1;
      winner = (bus.iReq0 && bus.iReq1) ? ~lastQ : bus.iReq1;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:  if (anyReq) stateD = StExec;
         StExec:  stateD = StDone;
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_comb begin
      bus.oGnt0 = (stateQ == StExec) && !idQ;
      bus.oGnt1 = (stateQ == StExec) && idQ;
      bus.oValid = (stateQ == StDone);
      bus.oBusy = (stateQ != StIdle);
   end

   always_comb begin
      gateOut = 1'b0;
      unique case (opQ)
         2'b00: gateOut = aQ & bQ;
         2'b01: gateOut = aQ | bQ;
         2'b10: gateOut = ~aQ;
         2'b11: gateOut = aQ ^ bQ;
         default: gateOut = 1'b0;
      endcase
   end

   // idQ tracks the in-flight winner; ownerQ holds the id of the last completed result.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         lastQ   <= 1'b1;
         idQ     <= 1'b0;
         opQ     <= 2'b00;
         aQ      <= 1'b0;
         bQ      <= 1'b0;
         resultQ <= 1'b0;
         ownerQ  <= 1'b0;
         countQ  <= 8'd0;
      end else begin
         if (stateQ == StIdle && anyReq) begin
            idQ   <= winner;
            lastQ <= winner;
            opQ   <= winner ? bus.iOp1 : bus.iOp0;
            aQ    <= winner ? bus.iA1 : bus.iA0;
            bQ    <= winner ? bus.iB1 : bus.iB0;
         end
         if (stateQ == StExec) begin
            resultQ <= gateOut;
            ownerQ  <= idQ;
            countQ  <= countQ + 8'd1;
         end
      end
   end

   assign bus.oResult = resultQ;
   assign bus.oId     = ownerQ;
   assign bus.oCount  = countQ;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Randomised plus directed bench for gate_unit_arbiter: a posedge reference model predicts
// grants and results into a scoreboard; a negedge monitor compares every cycle.
module tb_gate_unit_arbiter;

   typedef struct {
      int epoch;
      int validEdge;
      bit id;
      bit result;
   } expT;

   logic iClk;
   logic iRst;
   gate_unit_arbiter_if bus ();

   gate_unit_arbiter dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   // Model state (written only by the model process)
   expT sb[$];
   int  edgeN = 0;
   int  freeAt = 0;
   int  grantEdge = -100;
   bit  grantId = 0;
   bit  lastServed = 1;
   int  rstEdge = -1;
   int  epoch = 0;

   // Monitor state (written only by the monitor process)
   int  nCmp = 0;
   int  nBad = 0;
   bit  heldRes = 0;
   bit  heldId = 0;
   int  heldCnt = 0;
   int  prevCnt = 0;
   bit  sawWrap = 0;

   // Stimulus state
   bit  hold0 = 0;
   bit  hold1 = 0;
   bit  done = 0;
   int  timeouts = 0;

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (act=running, req=finished)");
      $fatal(1, "watchdog");
   end

   function automatic bit refGate(input int op, input int a, input int b);
      case (op)
         0: return bit'(a * b);
         1: return bit'((a + b) > 0);
         2: return bit'(1 - a);
         default: return bit'((a + b) % 2);
      endcase
   endfunction

   // Reference model: one operation per three edges, round-robin on ties.
   initial begin
      int  op;
      int  a;
      int  b;
      bit  w;
      expT it;
      forever begin
         @(posedge iClk);
         edgeN = edgeN + 1;
         if (iRst) begin
            lastServed = 1;
            freeAt = edgeN + 1;
            grantEdge = -100;
            rstEdge = edgeN;
            epoch = epoch + 1;
         end else if (edgeN >= freeAt && (bus.iReq0 || bus.iReq1)) begin
            w  = (bus.iReq0 && bus.iReq1) ? !lastServed : bus.iReq1;
            op = w ? int'(bus.iOp1) : int'(bus.iOp0);
            a  = w ? int'(bus.iA1) : int'(bus.iA0);
            b  = w ? int'(bus.iB1) : int'(bus.iB0);
            it.epoch = epoch;
            it.validEdge = edgeN + 1;
            it.id = w;
            it.result = refGate(op, a, b);
            sb.push_back(it);
            grantEdge = edgeN;
            grantId = w;
            lastServed = w;
            freeAt = edgeN + 3;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      nCmp = nCmp + 1;
      if (act !== exp) begin
         nBad = nBad + 1;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edgeN, act, exp);
      end
   endtask

   // Monitor: compares every cycle once the first reset edge has been seen.
   initial begin
      int  e;
      bit  expValid;
      expT it;
      forever begin
         @(negedge iClk);
         if (rstEdge >= 0) begin
            e = edgeN;
            if (rstEdge == e) begin
               heldRes = 0;
               heldId = 0;
               heldCnt = 0;
            end
            // Entries from before a reset were abandoned.
            while (sb.size() > 0 && sb[0].epoch != epoch) void'(sb.pop_front());
            expValid = (sb.size() > 0) && (sb[0].validEdge == e);
            check("valid", int'(bus.oValid), int'(expValid));
            if (expValid) begin
               it = sb.pop_front();
               heldRes = it.result;
               heldId = it.id;
               heldCnt = (heldCnt + 1) % 256;
            end
            check("gnt0", int'(bus.oGnt0), int'(grantEdge == e && grantId == 0));
            check("gnt1", int'(bus.oGnt1), int'(grantEdge == e && grantId == 1));
            check("gnt_overlap", int'(bus.oGnt0 && bus.oGnt1), 0);
            check("busy", int'(bus.oBusy), int'(grantEdge == e || grantEdge == e - 1));
            check("result", int'(bus.oResult), int'(heldRes));
            check("id", int'(bus.oId), int'(heldId));
            check("count", int'(bus.oCount), heldCnt);
            if (prevCnt == 255 && int'(bus.oCount) == 0 && rstEdge != e) sawWrap = 1;
            prevCnt = int'(bus.oCount);
            if (done) begin
               while (sb.size() > 0 && sb[0].epoch != epoch) void'(sb.pop_front());
               check("scoreboard_empty", sb.size(), 0);
               check("count_wrapped", int'(sawWrap), 1);
               check("grant_timeouts", timeouts, 0);
               $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
               $finish;
            end
         end
      end
   end

   task automatic reroll(input int id);
      if (id == 0) begin
         bus.iOp0 = 2'($urandom_range(0, 3));
         bus.iA0 = 1'($urandom_range(0, 1));
         bus.iB0 = 1'($urandom_range(0, 1));
      end else begin
         bus.iOp1 = 2'($urandom_range(0, 3));
         bus.iA1 = 1'($urandom_range(0, 1));
         bus.iB1 = 1'($urandom_range(0, 1));
      end
   endtask

   // Requesters drop on grant, or keep requesting with fresh operands in hold mode.
   task automatic tick();
      @(negedge iClk);
      if (bus.oGnt0) begin
         if (hold0) reroll(0);
         else bus.iReq0 = 1'b0;
      end
      if (bus.oGnt1) begin
         if (hold1) reroll(1);
         else bus.iReq1 = 1'b0;
      end
   endtask

   task automatic doReset();
      iRst = 1'b1;
      repeat (2) tick();
      iRst = 1'b0;
   endtask

   task automatic issue(input int id, input logic [1:0] op, input logic a, input logic b);
      int n;
      n = 0;
      if (id == 0) begin
         bus.iOp0 = op; bus.iA0 = a; bus.iB0 = b; bus.iReq0 = 1'b1;
      end else begin
         bus.iOp1 = op; bus.iA1 = a; bus.iB1 = b; bus.iReq1 = 1'b1;
      end
      while (((id == 0) ? bus.iReq0 : bus.iReq1) && n < 20) begin
         tick();
         n++;
      end
      if ((id == 0) ? bus.iReq0 : bus.iReq1) begin
         timeouts++;
         bus.iReq0 = 1'b0;
         bus.iReq1 = 1'b0;
      end
      repeat (2) tick();
   endtask

   initial begin
      int n;
      iRst = 1'b1;
      bus.iReq0 = 1'b0; bus.iOp0 = 2'b00; bus.iA0 = 1'b0; bus.iB0 = 1'b0;
      bus.iReq1 = 1'b0; bus.iOp1 = 2'b00; bus.iA1 = 1'b0; bus.iB1 = 1'b0;
      repeat (3) tick();
      iRst = 1'b0;
      repeat (2) tick();

      // Single AND operation on requester 0
      issue(0, 2'b00, 1'b1, 1'b1);

      // Every op and operand pair on requester 1
      for (int op = 0; op < 4; op++) begin
         for (int ab = 0; ab < 4; ab++) issue(1, 2'(op), ab[1], ab[0]);
      end

      // Tie held continuously from reset
      doReset();
      hold0 = 1; hold1 = 1;
      reroll(0); reroll(1);
      bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
      repeat (14) tick();

      // Reset during EXEC with the tie still held
      n = 0;
      while (!(bus.oGnt0 || bus.oGnt1) && n < 10) begin
         tick();
         n++;
      end
      if (!(bus.oGnt0 || bus.oGnt1)) timeouts++;
      iRst = 1'b1;
      tick();
      iRst = 1'b0;
      repeat (8) tick();

      // Back-to-back operations across the counter wrap
      bus.iReq1 = 1'b0; hold1 = 0;
      repeat (256 * 3 + 9) tick();
      bus.iReq0 = 1'b0; hold0 = 0;
      repeat (4) tick();

      // Requester 1 pulses for one cycle while requester 0 is being served
      bus.iReq0 = 1'b1; reroll(0);
      n = 0;
      while (!bus.oGnt0 && n < 10) begin
         tick();
         n++;
      end
      if (!bus.oGnt0) timeouts++;
      bus.iReq1 = 1'b1; reroll(1);
      tick();
      bus.iReq1 = 1'b0;
      repeat (5) tick();

      // Random traffic with withdrawals and occasional resets
      for (int i = 0; i < 600; i++) begin
         if (!bus.iReq0 && $urandom_range(0, 3) == 0) begin reroll(0); bus.iReq0 = 1'b1; end
         else if (bus.iReq0 && $urandom_range(0, 15) == 0) bus.iReq0 = 1'b0;
         if (!bus.iReq1 && $urandom_range(0, 3) == 0) begin reroll(1); bus.iReq1 = 1'b1; end
         else if (bus.iReq1 && $urandom_range(0, 15) == 0) bus.iReq1 = 1'b0;
         iRst = ($urandom_range(0, 96) == 0);
         tick();
      end
      iRst = 1'b0;
      bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
      repeat (6) tick();
      done = 1;
      repeat (5) tick();
   end

endmodule
